// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the RV32M mul/div unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            valid;
  logic            stall;
  logic            busy;

  modport master (
    output start, flush, func3, op_a, op_b,
    input  result, valid, stall, busy
  );

  modport slave (
    input  start, flush, func3, op_a, op_b,
    output result, valid, stall, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (2-cycle MUL, 33-cycle restoring DIV).
// Optional MULDIV_REM_FUSE_EN: reuse the last division's quotient/remainder.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t          r_state;
  logic [1:0]      r_f;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_res;
  logic [4:0]      r_cnt;
  logic            r_negq;
  logic            r_negr;
  logic            r_valid;

  logic            w_acc;
  logic            w_sgn;
  logic            w_dz;
  logic            w_ovf;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_res;
  logic            w_c_mul;
  logic            w_c_dz;
  logic            w_c_ovf;
  logic            w_c_hit;
  logic            w_c_run;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [63:0]     w_ma;
  logic [63:0]     w_mb;
  logic [63:0]     w_prod;
  logic [XLEN-1:0] w_mres;
  logic [XLEN:0]   w_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_rem_n;
  logic [XLEN-1:0] w_quo_n;
  logic [XLEN-1:0] w_qf;
  logic [XLEN-1:0] w_rf;
  logic [XLEN-1:0] w_div_res;
  logic            w_last;

  assign w_acc = (r_state == S_IDLE) & bus.start & ~bus.flush;
  assign w_sgn = ~bus.func3[0];
  assign w_dz  = (bus.op_b == '0);
  assign w_ovf = w_sgn & (bus.op_a == 32'h8000_0000)
               & (bus.op_b == 32'hFFFF_FFFF);

  assign w_c_mul = ~bus.func3[2];
  assign w_c_dz  = bus.func3[2] & w_dz;
  assign w_c_ovf = bus.func3[2] & ~w_dz & w_ovf;
  assign w_c_hit = bus.func3[2] & ~w_dz & ~w_ovf & w_hit;
  assign w_c_run = bus.func3[2] & ~w_dz & ~w_ovf & ~w_hit;

  assign w_abs_a = (w_sgn & bus.op_a[31]) ? -bus.op_a : bus.op_a;
  assign w_abs_b = (w_sgn & bus.op_b[31]) ? -bus.op_b : bus.op_b;

  // 33x33 signed product; only the low 64 bits are ever needed
  assign w_ma = {{32{(r_f != 2'b11) & r_a[31]}}, r_a};
  assign w_mb = {{32{(r_f == 2'b01) & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_mres = (r_f == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  assign w_sh    = {r_rem, r_quo[31]};
  assign w_ge    = (w_sh >= {1'b0, r_dvs});
  assign w_sub   = w_sh[XLEN-1:0] - r_dvs;
  assign w_rem_n = w_ge ? w_sub : w_sh[XLEN-1:0];
  assign w_quo_n = {r_quo[XLEN-2:0], w_ge};
  assign w_qf    = r_negq ? -w_quo_n : w_quo_n;
  assign w_rf    = r_negr ? -w_rem_n : w_rem_n;
  assign w_div_res = r_f[1] ? w_rf : w_qf;
  assign w_last  = (r_state == S_DIV) & (r_cnt == 5'd31);

`ifdef MULDIV_REM_FUSE_EN
  logic            r_cv;
  logic            r_cs;
  logic [XLEN-1:0] r_ca;
  logic [XLEN-1:0] r_cb;
  logic [XLEN-1:0] r_cq;
  logic [XLEN-1:0] r_cr;

  assign w_hit = r_cv & (r_cs == w_sgn) & (r_ca == bus.op_a)
               & (r_cb == bus.op_b);
  assign w_hit_res = bus.func3[1] ? r_cr : r_cq;

  // Survives flush; only a completed long division refreshes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cv <= 1'b0;
      r_cs <= 1'b0;
      r_ca <= '0;
      r_cb <= '0;
      r_cq <= '0;
      r_cr <= '0;
    end else if (w_last & ~bus.flush) begin
      r_cv <= 1'b1;
      r_cs <= ~r_f[0];
      r_ca <= r_a;
      r_cb <= r_b;
      r_cq <= w_qf;
      r_cr <= w_rf;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (bus.start) begin
            r_f <= bus.func3[1:0];
            r_a <= bus.op_a;
            r_b <= bus.op_b;
            unique case (1'b1)
              w_c_mul: r_state <= S_MUL;
              w_c_dz: begin
                r_state <= S_FIN;
                r_valid <= 1'b1;
                r_res   <= bus.func3[1] ? bus.op_a : '1;
              end
              w_c_ovf: begin
                r_state <= S_FIN;
                r_valid <= 1'b1;
                r_res   <= bus.func3[1] ? '0 : 32'h8000_0000;
              end
              w_c_hit: begin
                r_state <= S_FIN;
                r_valid <= 1'b1;
                r_res   <= w_hit_res;
              end
              w_c_run: begin
                r_state <= S_DIV;
                r_quo   <= w_abs_a;
                r_rem   <= '0;
                r_dvs   <= w_abs_b;
                r_cnt   <= '0;
                r_negq  <= w_sgn & (bus.op_a[31] ^ bus.op_b[31]);
                r_negr  <= w_sgn & bus.op_a[31];
              end
            endcase
          end
        end
        S_MUL: begin
          r_state <= S_FIN;
          r_valid <= 1'b1;
          r_res   <= w_mres;
        end
        S_DIV: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_state <= S_FIN;
            r_valid <= 1'b1;
            r_res   <= w_div_res;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_res;
  assign bus.valid  = r_valid;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.stall  = ~rst & (w_acc | (r_state == S_MUL)
                    | (r_state == S_DIV));

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic model.
// Build with +define+MULDIV_REM_FUSE_EN to cover the remainder-fuse cache.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MULDIV_REM_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  bit          mc_v = 1'b0;
  bit          mc_s;
  logic [31:0] mc_a;
  logic [31:0] mc_b;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat);
    longint sa, sb, ua, ub, p, q, r;
    bit sg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (!f[2]) begin
      lat = 2;
      case (f[1:0])
        2'b00:   p = sa * sb;
        2'b01:   p = sa * sb;
        2'b10:   p = sa * ub;
        default: p = ua * ub;
      endcase
      res = (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end else begin
      sg = !f[0];
      if (b == 0) begin
        lat = 1;
        res = f[1] ? a : 32'hFFFF_FFFF;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lat = 1;
        res = f[1] ? 32'h0 : 32'h8000_0000;
      end else begin
        if (sg) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        res = f[1] ? r[31:0] : q[31:0];
        if (FUSE && mc_v && mc_s == sg && mc_a == a && mc_b == b) begin
          lat = 1;
        end else begin
          lat = 33;
          mc_v = 1'b1;
          mc_s = sg;
          mc_a = a;
          mc_b = b;
        end
      end
    end
  endtask

  // Called at posedge+#1 while the unit is idle
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int k;
    int bad;
    model(f, a, b, exp, lat);
    bus.start = 1'b1;
    bus.func3 = f;
    bus.op_a  = a;
    bus.op_b  = b;
    #1;
    check({tag, ".stall_acc"}, 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    k = 1;
    bad = 0;
    while (!bus.valid && k <= 40) begin
      if (bus.stall !== 1'b1) bad++;
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, ".lat"}, 32'(k), 32'(lat));
    check({tag, ".res"}, bus.result, exp);
    check({tag, ".stall"}, 32'(bad) + 32'(bus.stall), 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(bus.valid), 32'd0);
  endtask

  task automatic abort_test(input bit use_rst);
    int nv;
    nv = 0;
    bus.start = 1'b1;
    bus.func3 = 3'b100;
    bus.op_a  = 32'd123457;
    bus.op_b  = 32'd67;
    @(posedge clk);
    #1;
    for (int i = 1; i < 10; i++) begin
      if (bus.valid) nv++;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    if (use_rst) rst = 1'b1;
    else bus.flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    if (use_rst) mc_v = 1'b0;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.stall", 32'(bus.stall), 32'd0);
    check("abort.valid", 32'(bus.valid) + 32'(nv), 32'd0);
    if (use_rst) check("abort.rst_res", bus.result, 32'd0);
    run_op("abort.mul", 3'b000, 32'd3, 32'd4);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = 3'b000;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.result", bus.result, 32'd0);
    check("rst.valid", 32'(bus.valid), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.func3 = 3'b000;
    #1;
    check("fl_start.stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    check("fl_start.busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 3'b101, 32'd100, 32'd7);
    run_op("remu", 3'b111, 32'd100, 32'd7);
    run_op("divu0", 3'b101, 32'd5, 32'd0);
    run_op("rem0", 3'b110, 32'd5, 32'd0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    abort_test(1'b0);
    abort_test(1'b1);

    run_op("fuse.div", 3'b100, 32'd100, 32'd7);
    run_op("fuse.rem", 3'b110, 32'd100, 32'd7);
    run_op("fuse.remu", 3'b111, 32'd100, 32'd7);

    ra = 32'd1;
    rb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ra = pick();
        rb = pick();
      end
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
